// File: rtl/cam_xclk_gen.sv
// Multi-channel programmable camera clock generator. Divisor changes and
// enable/disable are applied only at period boundaries so no runt pulses occur.
module cam_xclk_gen #(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned DIV_W       = 8,
  parameter int unsigned DEFAULT_DIV = 4,
  localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_in,
  input  logic              reset_n,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [NUM_CH-1:0] ch_en,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] rise_stb,
  output logic [NUM_CH-1:0] active,
  output logic [NUM_CH-1:0] cfg_pending
);

  typedef enum logic {IDLE, RUN} state_e;

  state_e           state_q    [NUM_CH];
  state_e           state_d    [NUM_CH];
  logic [DIV_W-1:0] cnt_q      [NUM_CH];
  logic [DIV_W-1:0] cnt_d      [NUM_CH];
  logic [DIV_W-1:0] cur_div_q  [NUM_CH];
  logic [DIV_W-1:0] cur_div_d  [NUM_CH];
  logic [DIV_W-1:0] pend_div_q [NUM_CH];
  logic [DIV_W-1:0] pend_div_d [NUM_CH];
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] clk_q, clk_d;
  logic [NUM_CH-1:0] stb_q, stb_d;
  logic [NUM_CH-1:0] act_q, act_d;

  logic             cfg_valid;
  logic [DIV_W-1:0] cfg_div_clamped;

  assign cfg_valid       = cfg_we && (32'(cfg_ch) < NUM_CH);
  assign cfg_div_clamped = (cfg_div < DIV_W'(2)) ? DIV_W'(2) : cfg_div;

  always_comb begin : next_state
    logic [DIV_W-1:0] hi_len;
    logic [DIV_W-1:0] last_cnt;
    hi_len     = '0;
    last_cnt   = '0;
    state_d    = state_q;
    cnt_d      = cnt_q;
    cur_div_d  = cur_div_q;
    pend_div_d = pend_div_q;
    pend_d     = pend_q;
    clk_d      = clk_q;
    act_d      = act_q;
    stb_d      = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      hi_len   = cur_div_q[i] - (cur_div_q[i] >> 1);
      last_cnt = cur_div_q[i] - DIV_W'(1);
      unique case (state_q[i])
        IDLE: begin
          cnt_d[i] = '0;
          clk_d[i] = 1'b0;
          act_d[i] = 1'b0;
          if (ch_en[i]) begin
            state_d[i] = RUN;
            clk_d[i]   = 1'b1;
            stb_d[i]   = 1'b1;
            act_d[i]   = 1'b1;
            if (pend_q[i]) begin
              cur_div_d[i] = pend_div_q[i];
              pend_d[i]    = 1'b0;
            end
          end
        end
        RUN: begin
          if (cnt_q[i] == last_cnt) begin
            cnt_d[i] = '0;
            if (ch_en[i]) begin
              clk_d[i] = 1'b1;
              stb_d[i] = 1'b1;
              if (pend_q[i]) begin
                cur_div_d[i] = pend_div_q[i];
                pend_d[i]    = 1'b0;
              end
            end else begin
              state_d[i] = IDLE;
              clk_d[i]   = 1'b0;
              act_d[i]   = 1'b0;
            end
          end else begin
            cnt_d[i] = cnt_q[i] + DIV_W'(1);
            clk_d[i] = (cnt_q[i] + DIV_W'(1)) < hi_len;
          end
        end
        default: state_d[i] = IDLE;
      endcase
      // A write coinciding with a commit lands after it: the commit took the old pend_div.
      if (cfg_valid && (cfg_ch == CH_W'(i))) begin
        pend_div_d[i] = cfg_div_clamped;
        pend_d[i]     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        state_q[i]    <= IDLE;
        cnt_q[i]      <= '0;
        cur_div_q[i]  <= DIV_W'(DEFAULT_DIV);
        pend_div_q[i] <= DIV_W'(DEFAULT_DIV);
      end
      pend_q <= '0;
      clk_q  <= '0;
      stb_q  <= '0;
      act_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cur_div_q  <= cur_div_d;
      pend_div_q <= pend_div_d;
      pend_q     <= pend_d;
      clk_q      <= clk_d;
      stb_q      <= stb_d;
      act_q      <= act_d;
    end
  end

  assign clk_out     = clk_q;
  assign rise_stb    = stb_q;
  assign active      = act_q;
  assign cfg_pending = pend_q;

endmodule

// File: doc/cam_xclk_gen.md
Name: cam_xclk_gen

Overview:
- Multi-channel, run-time programmable camera clock generator derived from the fabric clock.
- Each channel drives one sensor XCLK or an auxiliary pixel-domain clock.
- Divisor changes and enable/disable take effect only at period boundaries, so no runt pulses reach the sensor.
- Adds per-channel rising-edge strobes and status flags for the SCCB/config sequencer.

Parameters:
- NUM_CH, 2, number of independent clock channels (>=1).
- DIV_W, 8, width of the divisor (full period in clk_in cycles).
- DEFAULT_DIV, 4, divisor loaded at reset (2 high + 2 low, i.e. clk_in/4).

Ports:
- clk_in  input  1  fabric clock; all logic on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- cfg_we  input  1  one-cycle write strobe for a new divisor.
- cfg_ch  input  max(1,$clog2(NUM_CH))  target channel of the write.
- cfg_div  input  DIV_W  new full-period divisor.
- ch_en  input  NUM_CH  per-channel run request, level-sensitive.
- clk_out  output  NUM_CH  generated clocks, registered.
- rise_stb  output  NUM_CH  one-cycle pulse, high in the cycle clk_out[i] goes 0->1.
- active  output  NUM_CH  channel is producing periods.
- cfg_pending  output  NUM_CH  a written divisor awaits commit.

Behaviour:
- Reset (async, reset_n=0), applied immediately, including mid-period:
  - clk_out=0, rise_stb=0, active=0, cfg_pending=0.
  - cnt=0, cur_div=DEFAULT_DIV, state IDLE.
- Per channel:
  - State: IDLE/RUN, cnt[DIV_W-1:0], cur_div, pend_div, pend.
  - H = cur_div - floor(cur_div/2) (high phase, ceil); L = floor(cur_div/2).
- Config write:
  - cfg_we=1 with cfg_ch<NUM_CH sets pend_div=max(cfg_div,2) and pend=1. Values 0 and 1 clamp to 2.
  - cfg_ch>=NUM_CH: ignored, no state change.
  - Write while pend=1: overwrites pend_div (last write wins).
- IDLE:
  - clk_out=0, active=0, cnt held at 0.
  - If ch_en[i]=1 at an edge:
    - On that edge: clk_out<=1, rise_stb<=1, active<=1, cnt<=0, state RUN.
    - If pend: cur_div<=pend_div, pend<=0.
  - Latency: ch_en sampled high -> clk_out high 1 cycle later.
- RUN:
  - cnt increments each cycle.
  - clk_out high for cnt 0..H-1, low for cnt H..cur_div-1.
  - Period boundary is the edge where cnt==cur_div-1:
    - If ch_en=1: cnt<=0, clk_out<=1, rise_stb<=1. If pend, commit pend_div to cur_div and clear pend. The new divisor governs the period starting on that edge.
    - If ch_en=0: clk_out stays 0, active<=0, state IDLE.
- ch_en deassert mid-period: the current period completes in full (full high and low phases); no truncation.
- Simultaneous write and boundary commit on the same channel:
  - The boundary commits the old pend_div.
  - The new write lands in pend_div with pend=1, committed at the following boundary.
- rise_stb is exactly one cycle wide, aligned with the cycle clk_out reads 1 after a 0.
- Channels are fully independent; writes to one never perturb another.
- Odd divisors have high phase one clk_in cycle longer than low phase. No negedge logic is used.

Test Plan:
- Reset release, ch_en[0]=1, default 4 -> clk_out[0] high 1 cycle after en, then 1100 repeating; rise_stb every 4 cycles; active=1.
- Write cfg_div=10 to ch0 mid-period -> cfg_pending[0]=1 until next boundary; current 4-cycle period completes, then 5 high / 5 low; pending clears on commit.
- cfg_div=5 on ch1 -> 3 high / 2 low; cfg_div=0 -> clamped, 1 high / 1 low; cfg_ch=3 with NUM_CH=2 -> no change.
- ch_en[0] dropped on 1st high cycle of div-6 period -> remaining 2 high + 3 low cycles emitted, then clk_out=0, active=0; no rise_stb.
- cfg_we on the boundary edge with an earlier pending value 8 and new value 12 -> period of 8 starts, pending=1 holds 12, period of 12 follows.
- reset_n asserted mid-high -> clk_out, active, cfg_pending drop immediately; after release, DEFAULT_DIV is active again.
